// File: rtl/wb_gpio_irq_ctrl.sv
// wb_gpio_irq_ctrl: Wishbone GPIO block with synchronised inputs, W1C edge status and per-pin IRQ enables.
module wb_gpio_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int IO_WIDTH = 38
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic [IO_WIDTH-1:0] io_oeb,
  output logic [2:0]          user_irq
);
  logic [IO_WIDTH-1:0] r_out, r_oeb, r_en, r_pol, r_stat, r_s1, r_s2, r_s3;
  logic                r_ack;
  logic [31:0]         r_dat;
  logic [1:0]          r_irq;
  logic                w_hit, w_we, w_unused;
  logic [5:0]          w_off;
  logic [4:0]          w_pair;
  logic [31:0]         w_bm, w_rdata;
  logic [IO_WIDTH-1:0] w_m, w_d, w_evt, w_clr;
  logic [63:0]         w_rv [0:7];

  function automatic logic [IO_WIDTH-1:0] f_wr(input logic [IO_WIDTH-1:0] cur, input logic en,
                                               input logic [IO_WIDTH-1:0] m, input logic [IO_WIDTH-1:0] d);
    return en ? (cur & ~m) | (d & m) : cur;
  endfunction

  assign w_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~r_ack;
  assign w_we     = w_hit & wbs_we_i;
  assign w_off    = wbs_adr_i[7:2];
  assign w_pair   = w_off[5:1];
  assign w_unused = &{1'b0, wbs_adr_i[1:0]};
  assign w_bm     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  // Odd word offsets address the HI half; truncation drops lanes beyond the last pin.
  assign w_m      = {IO_WIDTH{w_we}} & IO_WIDTH'(w_off[0] ? {w_bm, 32'd0} : {32'd0, w_bm});
  assign w_d      = IO_WIDTH'({wbs_dat_i, wbs_dat_i});
  assign w_clr    = (w_pair == 5'd4) ? (w_m & w_d) : '0;
  assign w_evt    = (r_pol & r_s3 & ~r_s2) | (~r_pol & ~r_s3 & r_s2);

  assign w_rv[0] = 64'(r_out);
  assign w_rv[1] = 64'(r_oeb);
  assign w_rv[2] = 64'(r_s2);
  assign w_rv[3] = 64'(r_en);
  assign w_rv[4] = 64'(r_stat);
  assign w_rv[5] = 64'(r_pol);
  assign w_rv[6] = '0;
  assign w_rv[7] = '0;
  assign w_rdata = (w_off[5:4] != 2'd0) ? 32'd0 :
                   w_off[0] ? w_rv[w_off[3:1]][63:32] : w_rv[w_off[3:1]][31:0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_out  <= '0;
      r_oeb  <= '1;
      r_en   <= '0;
      r_pol  <= '0;
      r_stat <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_irq  <= '0;
    end else begin
      r_s1   <= io_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_out  <= f_wr(r_out, w_pair == 5'd0, w_m, w_d);
      r_oeb  <= f_wr(r_oeb, w_pair == 5'd1, w_m, w_d);
      r_en   <= f_wr(r_en,  w_pair == 5'd3, w_m, w_d);
      r_pol  <= f_wr(r_pol, w_pair == 5'd5, w_m, w_d);
      r_stat <= (r_stat & ~w_clr) | w_evt;
      r_ack  <= w_hit;
      r_dat  <= (w_hit & ~wbs_we_i) ? w_rdata : '0;
      r_irq  <= {|(r_stat[IO_WIDTH-1:32] & r_en[IO_WIDTH-1:32]), |(r_stat[31:0] & r_en[31:0])};
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign io_out    = r_out;
  assign io_oeb    = r_oeb;
  assign user_irq  = {1'b0, r_irq};
endmodule

// File: tb/tb_wb_gpio_irq_ctrl.sv
// tb_wb_gpio_irq_ctrl: directed test-plan sequences plus randomized bus/pin traffic against a cycle model.
module tb_wb_gpio_irq_ctrl;
  localparam int W = 38;
  localparam logic [63:0] VM = (64'd1 << W) - 64'd1;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat = 0, dat_o, rdv;
  logic ack;
  logic [W-1:0] io_in = 0, io_out, io_oeb;
  logic [2:0] irq;
  int total = 0, bad = 0;

  logic [63:0] m_out, m_oeb, m_en, m_pol, m_stat;
  logic m_ack;
  logic [31:0] m_dat;
  logic [2:0] m_irq;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  wb_gpio_irq_ctrl #(.BASE_ADDR(BASE), .IO_WIDTH(W)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(irq));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_oeb = VM; m_en = 0; m_pol = 0; m_stat = 0;
    m_ack = 0; m_dat = 0; m_irq = 0;
    q = '{64'd0, 64'd0, 64'd0, 64'd0};
  endtask

  // q[0] is the newest io_in sample; IN shows the pins as sampled two edges back.
  function automatic logic [31:0] rdw(input int off);
    logic [63:0] v;
    case (off / 2)
      0: v = m_out;
      1: v = m_oeb;
      2: v = q[1];
      3: v = m_en;
      4: v = m_stat;
      5: v = m_pol;
      default: v = 0;
    endcase
    return (off >= 12) ? 32'd0 : ((off & 1) != 0) ? v[63:32] : v[31:0];
  endfunction

  function automatic logic [63:0] wr(input logic [63:0] cur, input int half, input logic [31:0] d, input logic [3:0] s);
    logic [63:0] m = 0;
    for (int b = 0; b < 4; b++) if (s[b]) m[half*32 + b*8 +: 8] = 8'hFF;
    return ((cur & ~m) | ({d, d} & m)) & VM;
  endfunction

  task automatic step();
    logic hit;
    int off;
    logic [31:0] rd;
    logic [63:0] evt, clr, s2, s3;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      hit = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
      off = int'(adr[7:2]);
      rd = rdw(off);
      m_irq = {1'b0, |(m_stat[63:32] & m_en[63:32]), |(m_stat[31:0] & m_en[31:0])};
      q.push_front(64'(io_in));
      void'(q.pop_back());
      s2 = q[2];
      s3 = q[3];
      evt = ((m_pol & s3 & ~s2) | (~m_pol & ~s3 & s2)) & VM;
      clr = 0;
      if (hit && we)
        case (off)
          0, 1: m_out = wr(m_out, off % 2, dat, sel);
          2, 3: m_oeb = wr(m_oeb, off % 2, dat, sel);
          6, 7: m_en = wr(m_en, off % 2, dat, sel);
          8, 9: clr = wr(64'd0, off % 2, dat, sel);
          10, 11: m_pol = wr(m_pol, off % 2, dat, sel);
          default: ;
        endcase
      m_stat = (m_stat & ~clr) | evt;
      m_ack = hit;
      m_dat = (hit && !we) ? rd : 32'd0;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/ack"}, 64'(ack), 64'(m_ack));
    chk({tag, "/dat"}, 64'(dat_o), 64'(m_dat));
    chk({tag, "/out"}, 64'(io_out), m_out);
    chk({tag, "/oeb"}, 64'(io_oeb), m_oeb);
    chk({tag, "/irq"}, 64'(irq), 64'(m_irq));
  endtask

  task automatic tick(input string tag);
    step();
    check_all(tag);
  endtask

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] r);
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
    tick("wb_hit");
    chk("wb_ack_rise", 64'(ack), 64'd1);
    r = dat_o;
    cyc = 0; stb = 0; we = 0;
    tick("wb_end");
    chk("wb_ack_width", 64'(ack), 64'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) tick("rst");
    chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("rst_out", 64'(io_out), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    rst_n = 1;
    tick("idle");

    wb(1, BASE, 32'hA5A5_5A5A, 4'b0011, rdv);
    chk("out_lo", 64'(io_out[31:0]), 64'h5A5A);
    wb(0, BASE, 0, 4'hF, rdv);
    chk("rd_out_lo", 64'(rdv), 64'h5A5A);

    wb(1, BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, rdv);
    chk("out_hi", 64'(io_out[37:32]), 64'h3F);
    wb(0, BASE + 32'h04, 0, 4'hF, rdv);
    chk("rd_out_hi", 64'(rdv), 64'h3F);

    wb(1, BASE + 32'h18, 32'h1, 4'hF, rdv);
    wb(1, BASE + 32'h28, 32'h0, 4'hF, rdv);
    io_in[0] = 1'b1;
    repeat (3) tick("rise0");
    chk("irq0_n3", 64'(irq[0]), 64'd0);
    tick("rise0");
    chk("irq0_n4", 64'(irq[0]), 64'd1);
    wb(0, BASE + 32'h20, 0, 4'hF, rdv);
    chk("stat_lo", 64'(rdv), 64'h1);
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h20; dat = 32'h1; sel = 4'h1;
    tick("w1c");
    chk("irq0_hold", 64'(irq[0]), 64'd1);
    cyc = 0; stb = 0; we = 0;
    tick("w1c_end");
    chk("irq0_drop", 64'(irq[0]), 64'd0);

    wb(1, BASE + 32'h2C, 32'h20, 4'hF, rdv);
    wb(1, BASE + 32'h1C, 32'h20, 4'hF, rdv);
    io_in[37] = 1'b1;
    repeat (6) tick("rise37");
    chk("irq1_rise_ignored", 64'(irq[1]), 64'd0);
    io_in[37] = 1'b0;
    repeat (4) tick("fall37");
    chk("irq1_fall", 64'(irq[1]), 64'd1);
    wb(0, BASE + 32'h24, 0, 4'hF, rdv);
    chk("stat_hi", 64'(rdv), 64'h20);
    io_in[37] = 1'b1;
    repeat (4) tick("rise37b");
    io_in[37] = 1'b0;
    repeat (2) tick("fall37b");
    wb(1, BASE + 32'h24, 32'h20, 4'h1, rdv);
    wb(0, BASE + 32'h24, 0, 4'hF, rdv);
    chk("set_wins", 64'(rdv), 64'h20);
    chk("irq1_kept", 64'(irq[1]), 64'd1);

    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick("miss");
      chk("miss_ack", 64'(ack), 64'd0);
    end
    cyc = 0; stb = 0;
    wb(0, BASE + 32'h80, 0, 4'hF, rdv);
    chk("rd_hole", 64'(rdv), 64'd0);

    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h04;
    tick("pre_rst");
    #2 rst_n = 0;
    #1 model_reset();
    chk("rst_mid_ack", 64'(ack), 64'd0);
    chk("rst_mid_dat", 64'(dat_o), 64'd0);
    chk("rst_mid_out", 64'(io_out), 64'd0);
    chk("rst_mid_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    cyc = 0; stb = 0;
    repeat (2) tick("rst_hold");
    rst_n = 1;
    wb(0, BASE + 32'h18, 0, 4'hF, rdv);
    chk("rst_en_lo", 64'(rdv), 64'd0);
    wb(0, BASE + 32'h2C, 0, 4'hF, rdv);
    chk("rst_pol_hi", 64'(rdv), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc = ($urandom % 4) != 0;
      stb = ($urandom % 3) != 0;
      we  = 1'($urandom % 2);
      sel = 4'($urandom);
      dat = $urandom;
      case ($urandom % 8)
        0: adr = BASE + 32'h100 + 32'(($urandom % 64) * 4);
        1: adr = BASE + 32'h80;
        default: adr = BASE + 32'(($urandom % 12) * 4);
      endcase
      if ($urandom % 3 == 0) io_in = io_in ^ (38'd1 << ($urandom % W));
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
